maple_frame_checker: RTL

Receive-side Maple Bus frame checker. It sits between the RX FIFO master stream (`m_axis_rx_*`) and the DMA/CPU consumer. It parses the 4-byte frame header and forwards header plus payload bytes. It verifies the trailing XOR check byte, strips it, and closes every outgoing frame with `tlast`. Per-frame status and saturating good/bad frame counters are exposed for the AXI-Lite control block.

---
 rtl/maple_frame_checker_if.sv | 14 +
 rtl/maple_frame_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/maple_frame_checker_if.sv
`default_nettype none
// ==== maple_frame_checker_if : byte-stream valid/ready bundle (rev 1.0) ====
interface maple_frame_checker_if #(
  parameter int W = 8
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/maple_frame_checker.sv
`default_nettype none
// ==== maple_frame_checker : Maple Bus RX header parse, XOR check, tlast framing (rev 1.0) ====
module maple_frame_checker #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_MAX_WORDS        = 255,
  parameter int C_CNT_WIDTH        = 16
) (
  input  wire logic                   aclk,
  input  wire logic                   areset,
  maple_frame_checker_if.slave        s_axis,
  maple_frame_checker_if.master       m_axis,
  output logic                        stat_valid,
  output logic                        stat_crc_ok,
  output logic                        stat_len_err,
  output logic [7:0]                  stat_cmd,
  output logic [7:0]                  stat_src,
  output logic [7:0]                  stat_dst,
  output logic [7:0]                  stat_len,
  output logic [C_CNT_WIDTH-1:0]      cnt_good,
  output logic [C_CNT_WIDTH-1:0]      cnt_bad,
  input  wire logic                   cnt_clear
);

  localparam logic [1:0] c_ST_HDR  = 2'd0;
  localparam logic [1:0] c_ST_PAY  = 2'd1;
  localparam logic [1:0] c_ST_CHK  = 2'd2;
  localparam logic [1:0] c_ST_DISC = 2'd3;
  localparam logic [C_CNT_WIDTH-1:0] c_CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                    r_state;
  logic [1:0]                    r_sub;
  logic [9:0]                    r_cnt;
  logic [C_AXIS_TDATA_WIDTH-1:0] r_x;
  logic                          r_crc;
  logic                          r_err;

  logic [C_AXIS_TDATA_WIDTH-1:0] w_byte;
  logic                          w_last;
  logic                          w_fwd_ok;
  logic                          w_acc;
  logic                          w_len_big;
  logic                          w_done;
  logic                          w_done_crc;
  logic                          w_done_err;

  assign w_byte        = s_axis.tdata;
  assign w_last        = s_axis.tlast;
  assign w_fwd_ok      = !m_axis.tvalid || m_axis.tready;
  assign s_axis.tready = (r_state == c_ST_CHK || r_state == c_ST_DISC) ? 1'b1 : w_fwd_ok;
  assign w_acc         = s_axis.tvalid && s_axis.tready;
  assign w_len_big     = (32'(stat_len) > C_MAX_WORDS);

  // Frame-end detection; any input tlast before CHK is a truncation.
  always_comb begin
    w_done     = 1'b0;
    w_done_crc = 1'b0;
    w_done_err = 1'b0;
    if (w_acc && w_last) begin
      w_done = 1'b1;
      case (r_state)
        c_ST_HDR, c_ST_PAY: begin
          w_done_crc = 1'b0;
          w_done_err = 1'b1;
        end
        c_ST_CHK: begin
          w_done_crc = (w_byte == r_x);
          w_done_err = r_err;
        end
        default: begin
          w_done_crc = r_crc;
          w_done_err = r_err;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= c_ST_HDR;
      r_sub         <= 2'd0;
      r_cnt         <= 10'd0;
      r_x           <= '0;
      r_crc         <= 1'b0;
      r_err         <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tlast  <= 1'b0;
      stat_len      <= 8'd0;
      stat_src      <= 8'd0;
      stat_dst      <= 8'd0;
      stat_cmd      <= 8'd0;
    end else begin
      if (m_axis.tready) m_axis.tvalid <= 1'b0;
      if (w_acc) begin
        case (r_state)
          c_ST_HDR: begin
            m_axis.tvalid <= 1'b1;
            m_axis.tdata  <= w_byte;
            m_axis.tlast  <= w_last;
            case (r_sub)
              2'd0: begin
                stat_len <= w_byte;
                r_x      <= w_byte;
                r_err    <= 1'b0;
                r_crc    <= 1'b0;
              end
              2'd1: begin
                stat_src <= w_byte;
                r_x      <= r_x ^ w_byte;
              end
              2'd2: begin
                stat_dst <= w_byte;
                r_x      <= r_x ^ w_byte;
              end
              default: begin
                stat_cmd <= w_byte;
                r_x      <= r_x ^ w_byte;
              end
            endcase
            if (w_last) begin
              r_sub   <= 2'd0;
              r_state <= c_ST_HDR;
            end else if (r_sub == 2'd3) begin
              r_sub <= 2'd0;
              if (w_len_big) begin
                r_err        <= 1'b1;
                m_axis.tlast <= 1'b1;
                r_state      <= c_ST_DISC;
              end else if (stat_len == 8'd0) begin
                m_axis.tlast <= 1'b1;
                r_state      <= c_ST_CHK;
              end else begin
                r_cnt   <= {stat_len, 2'b00};
                r_state <= c_ST_PAY;
              end
            end else begin
              r_sub <= r_sub + 2'd1;
            end
          end
          c_ST_PAY: begin
            m_axis.tvalid <= 1'b1;
            m_axis.tdata  <= w_byte;
            r_x           <= r_x ^ w_byte;
            r_cnt         <= r_cnt - 10'd1;
            if (w_last) begin
              m_axis.tlast <= 1'b1;
              r_state      <= c_ST_HDR;
            end else if (r_cnt == 10'd1) begin
              m_axis.tlast <= 1'b1;
              r_state      <= c_ST_CHK;
            end else begin
              m_axis.tlast <= 1'b0;
            end
          end
          c_ST_CHK: begin
            r_crc <= (w_byte == r_x);
            if (w_last) begin
              r_state <= c_ST_HDR;
            end else begin
              r_err   <= 1'b1;
              r_state <= c_ST_DISC;
            end
          end
          default: begin
            if (w_last) r_state <= c_ST_HDR;
          end
        endcase
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_valid   <= 1'b0;
      stat_crc_ok  <= 1'b0;
      stat_len_err <= 1'b0;
    end else begin
      stat_valid <= w_done;
      if (w_done) begin
        stat_crc_ok  <= w_done_crc;
        stat_len_err <= w_done_err;
      end
    end
  end

  // Clear wins over an increment in the same cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_good <= '0;
      cnt_bad  <= '0;
    end else if (cnt_clear) begin
      cnt_good <= '0;
      cnt_bad  <= '0;
    end else if (w_done) begin
      if (w_done_crc && !w_done_err) begin
        if (cnt_good != '1) cnt_good <= cnt_good + c_CNT_ONE;
      end else begin
        if (cnt_bad != '1) cnt_bad <= cnt_bad + c_CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire
